sgd_mem_rd_cmd_gen: RTL

- Upstream stage of the training-dataset read path.
- Turns one host-level read job (base address, number of 512-bit cache lines) into a sequence of axis_mem_cmd requests to the memory controller.
- Each request is split at CHUNK_BYTES-aligned boundaries.
- A credit window sized to the 2^`A_FIFO_DEPTH_BITS`-line A FIFO ensures returned data can never overflow that FIFO.

---
 rtl/sgd_mem_rd_cmd_gen_pkg.sv | 23 ++
 rtl/sgd_mem_rd_cmd_gen_if.sv | 13 +
 rtl/sgd_credit_counter.sv | 46 ++++
 rtl/sgd_mem_rd_cmd_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sgd_mem_rd_cmd_gen_pkg.sv
// Shared constants, FSM encoding and helpers for the SGD dataset read-path
// command generators (A and B paths).
package sgd_mem_rd_cmd_gen_pkg;

    localparam int CL_BYTES          = 64;
    localparam int CL_SHIFT          = $clog2(CL_BYTES);
    localparam int A_FIFO_DEPTH_BITS = 11;

    localparam logic [7:0] MEM_RD_A_TAG = 8'd0;
    localparam logic [7:0] MEM_RD_B_TAG = 8'd1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic logic [31:0] cls_to_bytes(input logic [31:0] cls);
        return cls << CL_SHIFT;
    endfunction

endpackage

// File: rtl/sgd_mem_rd_cmd_gen_if.sv
// axis_mem_cmd request channel: the generator is the master, the memory
// controller the slave.
interface sgd_mem_rd_cmd_gen_if;

    logic        valid;
    logic        ready;
    logic [63:0] address;
    logic [31:0] length;

    modport master (output valid, output address, output length, input ready);
    modport slave  (input valid, input address, input length, output ready);

endinterface

// File: rtl/sgd_credit_counter.sv
// Saturating credit counter: one unit back per cycle, any amount taken per
// cycle, clamped to [0, MAX]. Resets full.
module sgd_credit_counter #(
    parameter int W   = 12,
    parameter int MAX = 2048
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic [W-1:0] i_dec,
    output logic [W-1:0] o_count
);

    localparam logic [W:0]   MAX_EXT = (W+1)'(MAX);
    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] r_count;
    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W-1:0] w_next;

    // next count: add the returned unit first so inc and dec may coincide
    always_comb begin
        w_sum  = {1'b0, r_count} + {{W{1'b0}}, i_inc};
        w_diff = w_sum - {1'b0, i_dec};
        if (w_sum < {1'b0, i_dec}) begin
            w_next = '0;
        end else if (w_diff > MAX_EXT) begin
            w_next = MAX_CNT;
        end else begin
            w_next = w_diff[W-1:0];
        end
    end

    // credit register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= MAX_CNT;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/sgd_mem_rd_cmd_gen.sv
// Splits one host read job into chunk-aligned axis_mem_cmd requests, gated by
// a credit window matching the downstream A FIFO depth.
module sgd_mem_rd_cmd_gen
    import sgd_mem_rd_cmd_gen_pkg::*;
#(
    parameter int CHUNK_CLS       = 64,
    parameter int FIFO_DEPTH_BITS = A_FIFO_DEPTH_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [63:0]          i_base_addr,
    input  logic [31:0]          i_num_cls,
    input  logic                 i_cl_pop,
    output logic                 o_busy,
    output logic                 o_done,
    sgd_mem_rd_cmd_gen_if.master cmd
);

    localparam int CHUNK_BITS = $clog2(CHUNK_CLS);
    localparam int LEN_W      = CHUNK_BITS + 1;
    localparam int CRED_W     = FIFO_DEPTH_BITS + 1;
    localparam int CRED_MAX   = 1 << FIFO_DEPTH_BITS;

    localparam logic [LEN_W-1:0] CHUNK_LEN = LEN_W'(CHUNK_CLS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [63:0]         r_addr;
    logic [31:0]         r_remaining;
    logic [31:0]         r_total;
    logic [31:0]         r_popped;
    logic [LEN_W-1:0]    r_len;
    logic                r_cmd_valid;
    logic [63:0]         r_cmd_address;
    logic [31:0]         r_cmd_length;
    logic                r_busy;
    logic                r_done;

    logic [CHUNK_BITS-1:0] w_offset;
    logic [LEN_W-1:0]      w_room;
    logic [LEN_W-1:0]      w_next_len;
    logic [CRED_W-1:0]     w_credits;
    logic [CRED_W-1:0]     w_cred_dec;
    logic                  w_cred_inc;
    logic                  w_hs;
    logic                  w_can_issue;
    logic                  w_pop_cnt;
    logic [31:0]           w_popped_next;

    // Lines left before the next chunk boundary is always in [1, CHUNK_CLS].
    assign w_offset = r_addr[CL_SHIFT+CHUNK_BITS-1:CL_SHIFT];
    assign w_room   = CHUNK_LEN - {1'b0, w_offset};

    // next command length: the job tail or the rest of the current chunk
    always_comb begin
        if (r_remaining < 32'(w_room)) begin
            w_next_len = LEN_W'(r_remaining);
        end else begin
            w_next_len = w_room;
        end
    end

    assign w_hs          = r_cmd_valid && cmd.ready;
    assign w_can_issue   = (r_state == ST_ISSUE) && !r_cmd_valid &&
                           (r_remaining != 32'd0) &&
                           (32'(w_credits) >= 32'(w_next_len));
    assign w_pop_cnt     = i_cl_pop && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));
    assign w_popped_next = r_popped + {31'd0, w_pop_cnt};
    assign w_cred_inc    = i_cl_pop && (r_state != ST_IDLE);
    assign w_cred_dec    = w_hs ? CRED_W'(r_len) : '0;

    sgd_credit_counter #(
        .W   (CRED_W),
        .MAX (CRED_MAX)
    ) u_credits (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_cred_inc),
        .i_dec   (w_cred_dec),
        .o_count (w_credits)
    );

    // job FSM next state; the pop landing this cycle counts toward completion
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_num_cls == 32'd0) ? ST_DONE : ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (w_hs && (r_remaining == 32'(r_len))) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (w_popped_next == r_total) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // job state, counters and the registered command channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= 64'd0;
            r_remaining   <= 32'd0;
            r_total       <= 32'd0;
            r_popped      <= 32'd0;
            r_len         <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_address <= 64'd0;
            r_cmd_length  <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
            r_done  <= (w_state_nxt == ST_DONE);
            if ((r_state == ST_IDLE) && i_start) begin
                r_addr      <= i_base_addr & ~64'h3F;
                r_remaining <= i_num_cls;
                r_total     <= i_num_cls;
                r_popped    <= 32'd0;
            end else begin
                r_popped <= w_popped_next;
                if (w_hs) begin
                    r_addr      <= r_addr + {32'd0, r_cmd_length};
                    r_remaining <= r_remaining - 32'(r_len);
                end
            end
            // valid drops for a cycle after every handshake
            if (w_hs) begin
                r_cmd_valid <= 1'b0;
            end else if (w_can_issue) begin
                r_cmd_valid   <= 1'b1;
                r_cmd_address <= r_addr;
                r_cmd_length  <= cls_to_bytes(32'(w_next_len));
                r_len         <= w_next_len;
            end
        end
    end

    assign cmd.valid   = r_cmd_valid;
    assign cmd.address = r_cmd_address;
    assign cmd.length  = r_cmd_length;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule
